// File: rtl/simple_reg_pkg.sv
// Shared definitions for the simple_reg_arb register arbiter: FSM encodings,
// default sizes and the index-width helper.
package simple_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DW_DEF   = 8;
    localparam int NREQ_DEF = 4;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simple_reg_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching ptr, ptr+1, ... modulo NREQ.
module simple_reg_rr_pick
    import simple_reg_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [IW:0]     sum  [NREQ];
    logic [IW-1:0]   pos  [NREQ];
    logic [NREQ-1:0] hit;

    // pos[gi] is the requester examined at search offset gi
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
        assign pos[gi] = IW'((sum[gi] >= (IW+1)'(NREQ)) ? sum[gi] - (IW+1)'(NREQ) : sum[gi]);
        assign hit[gi] = req[pos[gi]];
    end

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any = 1'b1;
                idx = pos[k];
            end
        end
    end

endmodule

// File: rtl/simple_reg_arb.sv
// Round-robin arbiter sharing one DW-bit register between NREQ valid/ready
// requesters. Optional grant locking is enabled by SIMPLE_REG_ARB_LOCK_EN.
module simple_reg_arb
    import simple_reg_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int HOLD_CYC = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          req_ready,
    output logic [DW-1:0]            d_out,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     upd,
    output logic                     busy
);

    localparam int            IW        = idx_width(NREQ);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
    localparam logic [3:0]    HOLD_INIT = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    state_t          state_reg, state_next;
    logic [IW-1:0]   gnt_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [3:0]      hold_cnt_reg;
    logic [DW-1:0]   d_out_reg;
    logic [IW-1:0]   owner_reg;
    logic            upd_reg;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            lock_hit;
    logic            xfer;
    logic [IW-1:0]   gnt_inc;
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
        assign data_arr[gi] = req_data[gi*DW +: DW];
    end

`ifdef SIMPLE_REG_ARB_LOCK_EN
    assign lock_hit = req_lock[gnt_reg];
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign lock_hit    = 1'b0;
`endif

    simple_reg_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // ready is driven from the state alone, so valid is the only handshake term
    assign xfer    = (state_reg == ST_WRITE) && req_valid[gnt_reg];
    assign gnt_inc = (gnt_reg == LAST_IDX) ? '0 : gnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (!req_valid[gnt_reg]) state_next = ST_IDLE;
                else if (lock_hit)       state_next = ST_WRITE;
                else if (HOLD_CYC > 0)   state_next = ST_HOLD;
                else                     state_next = ST_IDLE;
            end
            ST_HOLD: begin
                if (hold_cnt_reg == 4'd0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == ST_WRITE) req_ready[gnt_reg] = 1'b1;
        busy = (state_reg != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            d_out_reg    <= '0;
            owner_reg    <= '0;
            upd_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            if (state_reg == ST_IDLE && pick_any) begin
                gnt_reg <= pick_idx;
            end
            if (xfer) begin
                d_out_reg <= data_arr[gnt_reg];
                owner_reg <= gnt_reg;
                upd_reg   <= 1'b1;
                // a locked grant keeps its priority position
                if (!lock_hit) begin
                    rr_ptr_reg   <= gnt_inc;
                    hold_cnt_reg <= HOLD_INIT;
                end
            end
            if (state_reg == ST_HOLD && hold_cnt_reg != 4'd0) begin
                hold_cnt_reg <= hold_cnt_reg - 4'd1;
            end
        end
    end

    assign d_out = d_out_reg;
    assign owner = owner_reg;
    assign upd   = upd_reg;

endmodule

// File: tb/tb_simple_reg_arb.sv
// Self-checking bench for simple_reg_arb (HOLD_CYC=3): directed steps followed
// by random traffic, all checked against a transaction-level reference model.
module tb_simple_reg_arb;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int HOLD = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ-1:0]     req_ready;
    logic [DW-1:0]       d_out;
    logic [1:0]          owner;
    logic                upd;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    simple_reg_arb #(.DW(DW), .NREQ(NREQ), .HOLD_CYC(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .d_out     (d_out),
        .owner     (owner),
        .upd       (upd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending grant index (-1 none), remaining cool-down
    // cycles, priority pointer and the register contents.
    int              m_pend = -1;
    int              m_cool = 0;
    int              m_ptr  = 0;
    int              m_own  = 0;
    logic [DW-1:0]   m_d    = '0;
    logic            m_upd  = 1'b0;
    logic [NREQ-1:0] m_hs   = '0;

    task automatic model_step();
        bit keep;
        keep  = 1'b0;
        m_hs  = '0;
        m_upd = 1'b0;
        if (reset) begin
            m_pend = -1; m_cool = 0; m_ptr = 0; m_d = '0; m_own = 0;
        end else if (m_pend >= 0) begin
            if (req_valid[m_pend]) begin
                m_hs[m_pend] = 1'b1;
                m_d   = req_data[m_pend*DW +: DW];
                m_own = m_pend;
                m_upd = 1'b1;
`ifdef SIMPLE_REG_ARB_LOCK_EN
                keep = req_lock[m_pend];
`endif
                if (!keep) begin
                    m_ptr  = (m_pend + 1) % NREQ;
                    m_pend = -1;
                    m_cool = HOLD;
                end
            end else begin
                m_pend = -1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int ix;
                ix = (m_ptr + k) % NREQ;
                if (req_valid[ix]) begin
                    m_pend = ix;
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] er;
        er = '0;
        if (m_pend >= 0) er[m_pend] = 1'b1;
        chk("ready", 32'(req_ready), 32'(er));
        chk("d_out", 32'(d_out), 32'(m_d));
        chk("owner", 32'(owner), 32'(m_own));
        chk("upd",   32'(upd), 32'(m_upd));
        chk("busy",  32'(busy), 32'((m_pend >= 0) || (m_cool > 0)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, last, c;
        int exp6 [6];
        reset = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_dout", 32'(d_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // single requester, latency
        req_valid = 4'b0100; req_data[23:16] = 8'hA5;
        tick();
        chk("t2_ready", 32'(req_ready), 32'h4);
        tick();
        chk("t2_dout", 32'(d_out), 32'hA5);
        chk("t2_owner", 32'(owner), 32'd2);
        chk("t2_upd", 32'(upd), 32'd1);
        req_valid = '0;
        repeat (6) tick();

        // contention with wrap, fresh pointer after reset
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
        req_valid = 4'hF;
        nw = 0; last = 0; c = 0;
        while (c < 60 && nw < 5) begin
            tick(); c++;
            if (upd) begin
                chk("t3_owner", 32'(owner), 32'(nw % NREQ));
                chk("t3_data", 32'(d_out), 32'(8'h10 + nw % NREQ));
                if (nw > 0) chk("t3_gap", 32'(cyc - last), 32'(HOLD + 2));
                last = cyc;
                nw++;
            end
        end
        chk("t3_count", 32'(nw), 32'd5);
        req_valid = '0;
        repeat (6) tick();

        // protocol violation: valid dropped while granted
        req_data[15:8] = 8'h77; req_valid = 4'b0010;
        tick();
        chk("t5_ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        tick();
        chk("t5_upd", 32'(upd), 32'd0);
        chk("t5_dout", 32'(d_out), 32'h10);
        chk("t5_busy", 32'(busy), 32'd0);
        req_valid = 4'hF;
        tick();
        chk("t5_ptr", 32'(req_ready), 32'h2);
        tick();
        chk("t5_write", 32'(d_out), 32'h77);

        // reset while a grant is outstanding
        c = 0;
        while (c < 12 && req_ready == '0) begin tick(); c++; end
        chk("t1_in_write", 32'(req_ready != '0), 32'd1);
        reset = 1'b1;
        tick();
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_dout", 32'(d_out), 32'h0);
        chk("t1_owner", 32'(owner), 32'h0);
        tick();
        reset = 1'b0; req_valid = '0;
        tick();

        // lock: requester 0 asks to keep the grant for its first transfers
`ifdef SIMPLE_REG_ARB_LOCK_EN
        exp6 = '{0, 0, 0, 0, 1, 0};
`else
        exp6 = '{0, 1, 0, 1, 0, 1};
`endif
        req_data[7:0] = 8'h20; req_data[15:8] = 8'h31;
        req_valid = 4'b0011; req_lock = 4'b0001;
        nw = 0; last = 0; c = 0;
        begin
            int cnt0;
            cnt0 = 0;
            while (c < 80 && nw < 6) begin
                tick(); c++;
                if (m_upd) begin
                    chk("t6_owner", 32'(owner), 32'(exp6[nw]));
`ifdef SIMPLE_REG_ARB_LOCK_EN
                    if (nw > 0 && nw < 4) chk("t6_gap", 32'(cyc - last), 32'd1);
`endif
                    if (m_own == 0) cnt0++;
                    last = cyc;
                    nw++;
                end
                req_lock[0] = (cnt0 < 3);
            end
        end
        chk("t6_count", 32'(nw), 32'd6);
        req_valid = '0; req_lock = '0;
        repeat (6) tick();

        // random traffic with occasional violations and resets
        for (int r = 0; r < 3000; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if (m_hs[i]) begin
                        if ($urandom_range(1, 0) == 1) req_data[i*DW +: DW] = 8'($urandom);
                        else req_valid[i] = 1'b0;
                    end else if ($urandom_range(63, 0) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            req_lock = 4'($urandom);
            reset = ($urandom_range(199, 0) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
